window_builder: RTL and testbench

WINDOW_BUILDER -- requirements
Module: window_builder

---
 rtl/noise_pkg.sv | 38 +++
 rtl/window_builder_if.sv | 23 ++
 rtl/line_buffer.sv | 27 ++
 rtl/window_builder.sv | 140 ++++++++++++++
 tb/tb_window_builder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/noise_pkg.sv
// rtl/noise_pkg.sv - shared image geometry, pixel and window-mapping definitions
package noise_pkg;

  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;
  localparam int PIX_W          = 8;
  localparam int WIN            = 3;
  localparam int NUM_CH         = 3;
  localparam int RGB_W          = NUM_CH * PIX_W;
  localparam int WIN_ELEMS      = WIN * WIN;
  localparam int WIN_BITS       = WIN_ELEMS * PIX_W;

  // Window element mapping: row 0 is the oldest line, column 0 the oldest pixel
  localparam int WIN_ROW_TOP    = 0;
  localparam int WIN_ROW_MID    = 1;
  localparam int WIN_ROW_BOT    = 2;
  localparam int WIN_COL_NEW    = WIN - 1;
  localparam int WIN_CENTER_IDX = WIN_ROW_MID * WIN + 1;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  function automatic int win_idx(input int wr, input int wc);
    return wr * WIN + wc;
  endfunction

  function automatic logic [PIX_W-1:0] rgb_chan(input rgb_t p, input int ch);
    case (ch)
      0:       return p.r;
      1:       return p.g;
      default: return p.b;
    endcase
  endfunction

endpackage

// File: rtl/window_builder_if.sv
// rtl/window_builder_if.sv - pixel stream in, 3x3 colour windows out
interface window_builder_if;
  import noise_pkg::*;

  logic                sof;
  logic                pixel_valid;
  logic [RGB_W-1:0]    pixel_data;
  logic [WIN_BITS-1:0] red_data;
  logic [WIN_BITS-1:0] green_data;
  logic [WIN_BITS-1:0] blue_data;
  logic                window_valid;
  logic                frame_done;

  modport master (
    output sof, pixel_valid, pixel_data,
    input  red_data, green_data, blue_data, window_valid, frame_done
  );

  modport slave (
    input  sof, pixel_valid, pixel_data,
    output red_data, green_data, blue_data, window_valid, frame_done
  );
endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one image line of RGB pixels, read-before-write at one address
module line_buffer
  import noise_pkg::*;
#(
  parameter int DEPTH = IMG_WIDTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [RGB_W-1:0] i_wr_data,
  output logic [RGB_W-1:0] o_rd_data
);

  logic [RGB_W-1:0] r_mem [DEPTH];

  // The read sees the value from one line ago; the write lands on the edge
  assign o_rd_data = r_mem[i_addr];

  // Contents carry no reset: row gating keeps stale data out of windows
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/window_builder.sv
// rtl/window_builder.sv - raster counters, line-buffer cascade and 3x3 RGB window registers
module window_builder
  import noise_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic            clk,
  input  logic            n_rst,
  window_builder_if.slave bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(WIN - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(WIN - 1);

  logic                w_accept;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [CW-1:0]       w_col_eff;
  logic [RW-1:0]       w_row_eff;
  logic [CW-1:0]       w_col_nxt;
  logic [RW-1:0]       w_row_nxt;
  logic                w_win_ok;
  logic                w_frame_end;

  logic [RGB_W-1:0]    w_lb0_rd;
  logic [RGB_W-1:0]    w_lb1_rd;
  rgb_t                w_pix;
  rgb_t                w_above1;
  rgb_t                w_above2;

  logic [WIN_BITS-1:0] r_win     [NUM_CH];
  logic [WIN_BITS-1:0] w_win_nxt [NUM_CH];
  logic [WIN_BITS-1:0] r_out     [NUM_CH];
  logic                r_window_valid;
  logic                r_frame_done;

  assign w_accept = bus.pixel_valid;
  assign w_pix    = rgb_t'(bus.pixel_data);
  assign w_above1 = rgb_t'(w_lb0_rd);
  assign w_above2 = rgb_t'(w_lb1_rd);

  // Position of the pixel being accepted (sof forces 0,0) and the raster step after it
  always_comb begin
    w_col_eff = bus.sof ? '0 : r_col;
    w_row_eff = bus.sof ? '0 : r_row;
    w_col_nxt = w_col_eff + CW'(1);
    w_row_nxt = w_row_eff;
    if (w_col_eff == COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row_eff == ROW_LAST) ? '0 : w_row_eff + RW'(1);
    end
    w_win_ok    = w_accept && (w_row_eff >= ROW_MIN) && (w_col_eff >= COL_MIN);
    w_frame_end = w_accept && (w_row_eff == ROW_LAST) && (w_col_eff == COL_LAST);
  end

  // Raster counters move only on accepted pixels
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  // First buffer holds line r-1; its read data cascades into the buffer holding line r-2
  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .AW    (CW)
  ) u_lb0 (
    .clk       (clk),
    .i_we      (w_accept),
    .i_addr    (w_col_eff),
    .i_wr_data (bus.pixel_data),
    .o_rd_data (w_lb0_rd)
  );

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .AW    (CW)
  ) u_lb1 (
    .clk       (clk),
    .i_we      (w_accept),
    .i_addr    (w_col_eff),
    .i_wr_data (w_lb0_rd),
    .o_rd_data (w_lb1_rd)
  );

  // Shift each window one column left and insert the new column (top = oldest line)
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_win_nxt[ch] = r_win[ch];
      for (int wr = 0; wr < WIN; wr++) begin
        for (int wc = 0; wc < WIN - 1; wc++) begin
          w_win_nxt[ch][win_idx(wr, wc)*PIX_W +: PIX_W] =
            r_win[ch][win_idx(wr, wc + 1)*PIX_W +: PIX_W];
        end
      end
      w_win_nxt[ch][win_idx(WIN_ROW_TOP, WIN_COL_NEW)*PIX_W +: PIX_W] = rgb_chan(w_above2, ch);
      w_win_nxt[ch][win_idx(WIN_ROW_MID, WIN_COL_NEW)*PIX_W +: PIX_W] = rgb_chan(w_above1, ch);
      w_win_nxt[ch][win_idx(WIN_ROW_BOT, WIN_COL_NEW)*PIX_W +: PIX_W] = rgb_chan(w_pix, ch);
    end
  end

  // Window registers shift per pixel; outputs only load complete interior windows
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_win[ch] <= '0;
        r_out[ch] <= '0;
      end
      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_window_valid <= w_win_ok;
      r_frame_done   <= w_frame_end;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (w_accept) begin
          r_win[ch] <= w_win_nxt[ch];
        end
        if (w_win_ok) begin
          r_out[ch] <= w_win_nxt[ch];
        end
      end
    end
  end

  assign bus.red_data     = r_out[0];
  assign bus.green_data   = r_out[1];
  assign bus.blue_data    = r_out[2];
  assign bus.window_valid = r_window_valid;
  assign bus.frame_done   = r_frame_done;

endmodule

// File: tb/tb_window_builder.sv
// tb/tb_window_builder.sv - randomized and directed self-checking bench for window_builder
module tb_window_builder;

  localparam int W = 4;
  localparam int H = 4;
  localparam logic [71:0] FIRST_RED = 72'h22_21_20_12_11_10_02_01_00;
  localparam logic [71:0] ALL_55    = {9{8'h55}};

  logic clk;
  logic n_rst;
  window_builder_if bus ();

  window_builder #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state: frame image by position and current raster position
  logic [23:0] mem [H][W];
  int          m_r, m_c;
  logic        exp_wv, exp_fd;
  logic [71:0] exp_red, exp_grn, exp_blu;
  int          exp_wv_cnt, exp_fd_cnt, dut_wv_cnt, dut_fd_cnt;
  logic [71:0] win_log [$];

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] pat(input int r, input int c);
    logic [7:0] red;
    red = 8'(16 * r + c);
    return {red, ~red, 8'h55};
  endfunction

  task automatic model_reset();
    m_r = 0; m_c = 0;
    exp_wv = 1'b0; exp_fd = 1'b0;
    exp_red = '0; exp_grn = '0; exp_blu = '0;
  endtask

  task automatic model_accept(input bit v, input bit s, input logic [23:0] d);
    exp_wv = 1'b0;
    exp_fd = 1'b0;
    if (v) begin
      if (s) begin m_r = 0; m_c = 0; end
      mem[m_r][m_c] = d;
      exp_fd = (m_r == H - 1) && (m_c == W - 1);
      if (m_r >= 2 && m_c >= 2) begin
        exp_wv = 1'b1;
        for (int wr = 0; wr < 3; wr++) begin
          for (int wc = 0; wc < 3; wc++) begin
            logic [23:0] p;
            int k;
            p = mem[m_r - 2 + wr][m_c - 2 + wc];
            k = 3 * wr + wc;
            exp_red[8*k +: 8] = p[23:16];
            exp_grn[8*k +: 8] = p[15:8];
            exp_blu[8*k +: 8] = p[7:0];
          end
        end
      end
      m_c++;
      if (m_c == W) begin
        m_c = 0;
        m_r = (m_r == H - 1) ? 0 : m_r + 1;
      end
    end
    if (exp_wv) exp_wv_cnt++;
    if (exp_fd) exp_fd_cnt++;
  endtask

  task automatic clear_counts();
    exp_wv_cnt = 0; exp_fd_cnt = 0; dut_wv_cnt = 0; dut_fd_cnt = 0;
    win_log.delete();
  endtask

  // Drive one cycle at the falling edge, let the rising edge act, check at the next falling edge
  task automatic step(input bit v, input bit s, input logic [23:0] d);
    bus.pixel_valid = v;
    bus.sof         = s;
    bus.pixel_data  = d;
    model_accept(v, s, d);
    @(posedge clk);
    @(negedge clk);
    bus.pixel_valid = 1'b0;
    bus.sof         = 1'b0;
    if (bus.window_valid === 1'b1) begin
      dut_wv_cnt++;
      win_log.push_back(bus.red_data);
    end
    if (bus.frame_done === 1'b1) dut_fd_cnt++;
    check("window_valid", {71'b0, bus.window_valid}, {71'b0, exp_wv});
    check("frame_done",   {71'b0, bus.frame_done},   {71'b0, exp_fd});
    check("red_data",     bus.red_data,   exp_red);
    check("green_data",   bus.green_data, exp_grn);
    check("blue_data",    bus.blue_data,  exp_blu);
  endtask

  task automatic apply_reset();
    bus.pixel_valid = 1'b0;
    bus.sof         = 1'b0;
    n_rst           = 1'b1;
    @(negedge clk);
    check("rst_window_valid", {71'b0, bus.window_valid}, 72'd0);
    check("rst_frame_done",   {71'b0, bus.frame_done},   72'd0);
    check("rst_red",   bus.red_data,   72'd0);
    check("rst_green", bus.green_data, 72'd0);
    check("rst_blue",  bus.blue_data,  72'd0);
    n_rst = 1'b0;
    model_reset();
  endtask

  task automatic run_frame(input bit first_sof, input int gap);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b1, first_sof && r == 0 && c == 0, pat(r, c));
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 24'(c));
      end
    end
  endtask

  task automatic check_counts(input string tag, input int wv, input int fd);
    check({tag, "_wv_cnt"}, 72'(dut_wv_cnt), 72'(wv));
    check({tag, "_fd_cnt"}, 72'(dut_fd_cnt), 72'(fd));
  endtask

  initial begin
    n_rst = 1'b1;
    bus.pixel_valid = 1'b0;
    bus.sof = 1'b0;
    bus.pixel_data = '0;
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) mem[r][c] = '0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // continuous frame with sof
    clear_counts();
    run_frame(1'b1, 0);
    check_counts("full", 4, 1);
    check("full_first_red", (win_log.size() > 0) ? win_log[0] : 72'hx, FIRST_RED);
    check("full_blue", bus.blue_data, ALL_55);

    // same frame with idle gaps of two cycles
    clear_counts();
    run_frame(1'b1, 2);
    check_counts("gap", 4, 1);
    check("gap_first_red", (win_log.size() > 0) ? win_log[0] : 72'hx, FIRST_RED);

    // two frames back to back, second without sof
    clear_counts();
    run_frame(1'b1, 0);
    run_frame(1'b0, 0);
    check_counts("b2b", 8, 2);
    check("b2b_second_red", (win_log.size() > 4) ? win_log[4] : 72'hx, FIRST_RED);

    // sof arrives where pixel (2,1) would have been
    clear_counts();
    for (int i = 0; i < 2 * W + 1; i++) step(1'b1, i == 0, pat(i / W, i % W));
    check_counts("abort_pre", 0, 0);
    run_frame(1'b1, 0);
    check_counts("abort", 4, 1);
    check("abort_first_red", (win_log.size() > 0) ? win_log[0] : 72'hx, FIRST_RED);

    // reset during row 3, then a frame with no sof
    clear_counts();
    for (int i = 0; i < 3 * W + 2; i++) step(1'b1, i == 0, pat(i / W, i % W));
    check_counts("prereset", 2, 0);
    apply_reset();
    clear_counts();
    run_frame(1'b0, 0);
    check_counts("postreset", 4, 1);
    check("postreset_first_red", (win_log.size() > 0) ? win_log[0] : 72'hx, FIRST_RED);

    // randomized pixels, gaps and occasional sof against the model
    clear_counts();
    for (int i = 0; i < 600; i++) begin
      bit v, s;
      v = ($urandom_range(0, 9) < 7);
      s = v && ($urandom_range(0, 49) == 0);
      step(v, s, 24'($urandom));
    end
    check_counts("rand", exp_wv_cnt, exp_fd_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
